adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter and sequencer that shares one instance of the combinational `adder` block among `R` requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the operands into the shared adder. It returns the sum, carry-out and requester ID over a single response handshake. It sits between the address/offset generators and the shared 32-bit adder, so duplicate adders are not needed.

## Interface
- `N`, default 32: operand/sum width; passed to the `adder` instance.
- `R`, default 4: number of requesters, ≥2; `IDW = $clog2(R)`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  R  per-requester operand valid
- `req_ready`  out  R  one-hot capture pulse to the granted requester
- `req_a`  in  R*N  flattened A operands; requester i at `[i*N +: N]`
- `req_b`  in  R*N  flattened B operands, same packing
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  IDW  index of the requester that owns the result
- `rsp_sum`  out  N  `a + b` mod 2^N
- `rsp_cout`  out  1  unsigned carry-out of the add
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If `req_valid != 0`, select the winner `g` round-robin.
  - Assert `req_ready[g]` for that cycle only.
  - Latch `req_a[g]`, `req_b[g]` and `g` into the operand registers.
  - Go to EXEC.
  - Otherwise stay in IDLE.
- Round-robin priority: search starts at `last_grant + 1` and wraps modulo R. `last_grant` updates on every capture. Reset value of `last_grant` is R-1, so requester 0 has top priority after reset.
- EXEC:
  - The shared `adder` sees the registered operands.
  - Register `rsp_sum = c`.
  - Register `rsp_cout = (a[N-1]&b[N-1]) | ((a[N-1]^b[N-1]) & ~c[N-1])`.
  - Register `rsp_id`, then go to RESP.
- RESP:
  - `rsp_valid = 1`; `rsp_sum`, `rsp_cout` and `rsp_id` are held stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
- Requester rules:
  - A requester holds `req_valid` and operands stable until it sees `req_ready`.
  - Withdrawing `req_valid` before the grant is legal and is ignored.
  - `req_valid` is only sampled in IDLE. Requests raised during EXEC/RESP wait.
- At most one `req_ready` bit is high in any cycle. `req_ready` is never high outside IDLE.
- Arithmetic is unsigned and wraps modulo 2^N. The only overflow indication is `rsp_cout`.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE
  - `req_ready=0`, `rsp_valid=0`, `rsp_sum=0`, `rsp_cout=0`, `rsp_id=0`, `busy=0`
  - operand registers 0
  - `last_grant=R-1`
- Latency: capture at edge k (the IDLE cycle with `req_ready` high). EXEC runs in cycle k+1. `rsp_valid` rises after edge k+2.
- Minimum spacing between captures is 3 cycles, when `rsp_ready` is tied high.
- Backpressure: with `rsp_ready` low, RESP holds indefinitely and all response outputs stay constant.
- `req_ready` is combinational from `req_valid` and `last_grant` in IDLE. `busy` is a pure decode of state.
- Reset asserted mid-EXEC or mid-RESP: the operation is dropped, no response is issued, and outputs take reset values immediately. After release, requesters with `req_valid` still high are re-arbitrated with requester 0 first.
- A request arriving in the same cycle the FSM returns to IDLE is grantable in the following cycle.

## Test plan
- Single request:
  - Stimulus: requester 2 sends `a=0x01B30FFF`, `b=0xFFA5FFFF`.
  - Required: `req_ready=4'b0100` for one cycle, then after 2 cycles `rsp_valid=1`, `rsp_id=2`, `rsp_sum=0x01590FFE`, `rsp_cout=1`.
- Fairness:
  - Stimulus: all four requesters held valid from reset with `rsp_ready=1`.
  - Required: grant order 0,1,2,3,0, with captures spaced exactly 3 cycles apart.
- Carry wrap:
  - Stimulus: `a=0xFFFFFFFF`, `b=0x00000001`. Then `a=987654321`, `b=123456789`.
  - Required: first result `rsp_sum=0`, `rsp_cout=1`. Second result `rsp_sum=1111111110`, `rsp_cout=0`.
- Backpressure:
  - Stimulus: `rsp_ready` low for 5 cycles during RESP while requester 1 is valid.
  - Required: response outputs stay constant, `req_ready` stays 0, `busy=1`. Requester 1 is granted in the cycle after the handshake completes.
- Reset mid-operation:
  - Stimulus: drop `rst_n` during EXEC.
  - Required: `rsp_valid` never asserts for that operation and all outputs go to 0 immediately. After release, a pending requester 3 and requester 0 are granted in the order 0 then 3.
- Withdrawal:
  - Stimulus: requester 1 raises and drops `req_valid` during RESP.
  - Required: no grant is ever issued to requester 1.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter/sequencer that shares one combinational
// adder among R requesters. Operands are captured from the granted requester,
// added in the EXEC cycle, and returned with carry-out and owner ID in RESP.
//
// Handshakes: a transfer happens on any rising clk edge where valid and ready
// are both high. req_ready is a single-cycle, one-hot capture pulse asserted
// only in IDLE; the requester must hold req_valid and operands stable until it
// sees it. rsp_valid stays high in RESP, and the response is held stable until
// rsp_ready is sampled high.

// Shared combinational adder: sum modulo 2^N, no carry port.
module adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_c
);
    assign o_c = i_a + i_b;
endmodule

module adder_arbiter #(
    parameter int N = 32,
    parameter int R = 4,
    localparam int IDW = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*N-1:0]   req_a,
    input  logic [R*N-1:0]   req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [N-1:0]     rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_last_grant;
    logic [N-1:0]     r_sum;
    logic             r_cout;
    logic [IDW-1:0]   r_rsp_id;

    logic [N-1:0]     w_sum;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic             w_capture;
    logic [R-1:0]     w_ready;

    assign w_any     = |req_valid;
    assign w_capture = (r_state == ST_IDLE) && w_any;

    // The one shared adder only ever sees the registered operands.
    adder #(.N(N)) u_adder (
        .i_a (r_a),
        .i_b (r_b),
        .o_c (w_sum)
    );

    // Round-robin pick: scan from last_grant+R down to last_grant+1 so the
    // closest valid requester after last_grant is the last one written.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        for (int k = R; k >= 1; k--) begin
            w_idx = IDW'((int'(r_last_grant) + k) % R);
            if (req_valid[w_idx]) begin
                w_grant = w_idx;
            end
        end
    end

    // One-hot capture pulse; forced low while reset is asserted so the
    // output matches its reset value even though IDLE decodes combinationally.
    always_comb begin
        w_ready = '0;
        if (rst_n && w_capture) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture in IDLE; result registration in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= '0;
            r_last_grant <= IDW'(R - 1);
            r_sum        <= '0;
            r_cout       <= 1'b0;
            r_rsp_id     <= '0;
        end else begin
            if (w_capture) begin
                r_a          <= req_a[w_grant*N +: N];
                r_b          <= req_b[w_grant*N +: N];
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == ST_EXEC) begin
                r_sum    <= w_sum;
                // Carry-out recovered from operand MSBs and the sum MSB.
                r_cout   <= (r_a[N-1] & r_b[N-1]) |
                            ((r_a[N-1] ^ r_b[N-1]) & ~w_sum[N-1]);
                r_rsp_id <= r_id;
            end
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (N=32, R=4): table-driven single
// requests, hand-written multi-cycle sequences, then randomized traffic
// checked against a transaction-level round-robin/sum model.
module tb_adder_arbiter;

    localparam int N   = 32;
    localparam int R   = 4;
    localparam int IDW = 2;
    localparam int W   = IDW + 1 + N;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [R-1:0]     req_valid = '0;
    logic [R-1:0]     req_ready;
    logic [R*N-1:0]   req_a = '0;
    logic [R*N-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [IDW-1:0]   rsp_id;
    logic [N-1:0]     rsp_sum;
    logic             rsp_cout;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    adder_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
    endtask

    // Asserts reset for two edges, checks reset outputs, releases away from the edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_rsp_id", rsp_id, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Starts at posedge+1; returns at the negedge of the grant cycle.
    task automatic wait_grant(output logic ok, output logic [R-1:0] mask);
        ok   = 1'b0;
        mask = '0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                ok   = 1'b1;
                mask = req_ready;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Starts at posedge+1; returns at posedge+1 once idle (or budget spent).
    task automatic drain();
        logic idle;
        idle      = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("drain_idle", idle, 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[8];

    task automatic run_single(input vec_t v);
        logic ok;
        logic [R-1:0] mask;
        req_valid       = '0;
        set_op(v.id, v.a, v.b);
        req_valid[v.id] = 1'b1;
        rsp_ready       = 1'b1;
        wait_grant(ok, mask);
        chk("single_grant_seen", ok, 1);
        chk("single_grant_mask", mask, 64'(1) << v.id);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("single_exec_no_valid", rsp_valid, 0);
        chk("single_exec_busy", busy, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, v.id);
        chk("single_rsp_sum", rsp_sum, v.sum);
        chk("single_rsp_cout", rsp_cout, v.cout);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("single_back_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Random-phase reference model state
    logic [R-1:0]  m_pending;
    logic [N-1:0]  m_a [R];
    logic [N-1:0]  m_b [R];
    int            m_last;
    logic [W-1:0]  exp_q[$];

    function automatic int pick();
        for (int k = 1; k <= R; k++) begin
            int idx;
            idx = (m_last + k) % R;
            if (m_pending[idx]) return idx;
        end
        return -1;
    endfunction

    initial begin
        logic ok;
        logic [R-1:0] mask;
        logic [R-1:0] gmask [5];
        int gcyc [5];
        int ng;
        int cyc;
        int exp_order [5];
        logic [IDW-1:0] first_rsp_id;
        logic got_rsp;
        int cap_cyc;
        logic prev_valid;
        int g;
        logic [N:0] s;
        logic [W-1:0] e;
        logic [IDW-1:0] eid;

        vecs[0] = '{2, 32'h01B3_0FFF, 32'hFFA5_FFFF, 32'h0159_0FFE, 1'b1};
        vecs[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[2] = '{1, 32'd987654321, 32'd123456789, 32'd1111111110, 1'b0};
        vecs[3] = '{3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[5] = '{3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[6] = '{1, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
        vecs[7] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};

        // Reset and table-driven single requests
        do_reset();
        for (int i = 0; i < 8; i++) run_single(vecs[i]);

        // Fairness: all four valid from reset, rsp_ready tied high
        for (int i = 0; i < R; i++) set_op(i, 32'(i * 16 + 1), 32'(i + 7));
        req_valid = '1;
        do_reset();
        ng  = 0;
        cyc = 0;
        for (int t = 0; t < 40 && ng < 5; t++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                gmask[ng] = req_ready;
                gcyc[ng]  = cyc;
                ng++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("fair_grant_count", ng, 5);
        exp_order = '{0, 1, 2, 3, 0};
        if (ng == 5) begin
            chk("fair_first_cycle", gcyc[0], 0);
            for (int i = 0; i < 5; i++) chk("fair_order", gmask[i], 64'(1) << exp_order[i]);
            for (int i = 1; i < 5; i++) chk("fair_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        drain();

        // Backpressure: requester 0 result held while requester 1 waits
        set_op(0, 32'h1111_1111, 32'h2222_2222);
        set_op(1, 32'hA5A5_A5A5, 32'h0101_0101);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        wait_grant(ok, mask);
        chk("bp_grant0", mask, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_sum", rsp_sum, 32'h3333_3333);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_rsp_cout", rsp_cout, 0);
            chk("bp_no_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_no_ready", req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_grant1_after_hs", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        drain();

        // Reset mid-EXEC, then requesters 0 and 3 re-arbitrated
        set_op(2, 32'h0F0F_0F0F, 32'h1010_1010);
        req_valid = 4'b0100;
        wait_grant(ok, mask);
        chk("rm_grant2", mask, 4'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("rm_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_rsp_valid", rsp_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_rsp_sum", rsp_sum, 0);
        chk("rm_rsp_id", rsp_id, 0);
        chk("rm_rsp_cout", rsp_cout, 0);
        set_op(0, 32'd5, 32'd6);
        set_op(3, 32'd100, 32'd200);
        req_valid = 4'b1001;
        repeat (2) begin
            @(negedge clk);
            chk("rm_hold_no_valid", rsp_valid, 0);
            chk("rm_hold_no_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ng      = 0;
        got_rsp = 1'b0;
        first_rsp_id = '1;
        for (int t = 0; t < 30 && (ng < 2 || !got_rsp); t++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready && !got_rsp) begin
                got_rsp      = 1'b1;
                first_rsp_id = rsp_id;
                chk("rm_first_rsp_sum", rsp_sum, 32'd11);
            end
            if (req_ready != 0 && ng < 2) begin
                gmask[ng] = req_ready;
                ng++;
            end
            mask = req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~mask;
        end
        chk("rm_grant_count", ng, 2);
        chk("rm_order_first", gmask[0], 4'b0001);
        chk("rm_order_second", gmask[1], 4'b1000);
        chk("rm_first_rsp_id", first_rsp_id, 0);
        drain();

        // Withdrawal: requester 1 raises and drops valid during RESP
        set_op(0, 32'd1, 32'd2);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        wait_grant(ok, mask);
        chk("wd_grant0", mask, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("wd_resp_no_grant", req_ready[1], 0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        rsp_ready    = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("wd_no_grant_1", req_ready[1], 0);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the transaction-level model
        req_valid = '0;
        do_reset();
        m_pending  = '0;
        m_last     = R - 1;
        cyc        = 0;
        cap_cyc    = -100;
        prev_valid = 1'b0;
        for (int t = 0; t < 1800; t++) begin
            @(negedge clk);
            g = -1;
            if (req_ready != 0) begin
                g = pick();
                chk("rand_grant", req_ready, (g >= 0) ? (64'(1) << g) : 64'(0));
                if (g >= 0) begin
                    s   = {1'b0, m_a[g]} + {1'b0, m_b[g]};
                    eid = IDW'(g);
                    exp_q.push_back({eid, s[N], s[N-1:0]});
                    m_last  = g;
                    cap_cyc = cyc;
                end
            end
            if (rsp_valid && !prev_valid) chk("rand_latency", cyc - cap_cyc, 2);
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rand_unexpected_rsp: got id %0d sum %0h, expected none", rsp_id, rsp_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_rsp_id", rsp_id, e[W-1 -: IDW]);
                    chk("rand_rsp_cout", rsp_cout, e[N]);
                    chk("rand_rsp_sum", rsp_sum, e[N-1:0]);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (g >= 0) m_pending[g] = 1'b0;
            for (int i = 0; i < R; i++) begin
                if (!m_pending[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        m_pending[i] = 1'b1;
                        m_a[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                        m_b[i] = $urandom;
                    end
                end else if (i != g && $urandom_range(0, 19) == 0) begin
                    m_pending[i] = 1'b0;
                end
                req_valid[i] = m_pending[i];
                set_op(i, m_a[i], m_b[i]);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        // Stop new traffic and collect the remaining response
        m_pending = '0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rand_tail_id", rsp_id, e[W-1 -: IDW]);
                chk("rand_tail_sum", rsp_sum, e[N-1:0]);
                chk("rand_tail_cout", rsp_cout, e[N]);
            end
            @(posedge clk);
            #1;
        end
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
